adder_accumulator: RTL

- Downstream consumer of the N-bit ripple adder: takes each result ({carry_out, sum}) over a valid/ready handshake.
- Accumulates COUNT consecutive results into a wider total with no overflow possible.
- Presents the batch total on a registered valid/ready output and counts completed batches.
- Feeds the result-reporting logic; one instance per adder.

---
 rtl/adder_accumulator.sv | 99 +++++++++
 1 files changed

// File: rtl/adder_accumulator.sv
// adder_accumulator: sums COUNT consecutive {carry, sum} adder results into a
// batch total that cannot overflow. The total is offered on a registered
// valid/ready output, and the block counts the batches it has handed off.
module adder_accumulator #(
   parameter int unsigned N = 2,
   parameter int unsigned COUNT = 4,
   localparam int unsigned ACC_W = N + 1 + $clog2(COUNT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             carry_in_bit,
   input  logic [N-1:0]     sum_in,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic [7:0]       batch_count
);

   localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]       state, state_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [ACC_W-1:0] total_n;
   logic             valid_n;
   logic [7:0]       bcount_n;
   logic [ACC_W-1:0] operand;
   logic             accept;
   logic             transfer;

   // Operand is the adder carry prepended to its sum, zero-extended.
   assign operand  = ACC_W'({carry_in_bit, sum_in});
   // The block takes input only while it is not holding a total.
   assign in_ready = (state == ACCUM);
   assign accept   = in_valid & in_ready;
   assign transfer = out_valid & out_ready;

   // Next-state and datapath update; clear overrides every handshake.
   always_comb begin
      state_n  = state;
      acc_n    = acc;
      cnt_n    = cnt;
      total_n  = out_total;
      valid_n  = out_valid;
      bcount_n = batch_count;
      if (clear) begin
         state_n = ACCUM;
         acc_n   = '0;
         cnt_n   = '0;
         valid_n = 1'b0;
      end else if (state == ACCUM) begin
         if (accept) begin
            if (cnt == CNT_LAST) begin
               total_n = acc + operand;
               acc_n   = '0;
               cnt_n   = '0;
               valid_n = 1'b1;
               state_n = HOLD;
            end else begin
               acc_n = acc + operand;
               cnt_n = cnt + CNT_W'(1);
            end
         end
      end else begin
         if (transfer) begin
            state_n  = ACCUM;
            valid_n  = 1'b0;
            bcount_n = batch_count + 8'd1;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ACCUM;
         acc         <= '0;
         cnt         <= '0;
         out_total   <= '0;
         out_valid   <= 1'b0;
         batch_count <= 8'd0;
      end else begin
         state       <= state_n;
         acc         <= acc_n;
         cnt         <= cnt_n;
         out_total   <= total_n;
         out_valid   <= valid_n;
         batch_count <= bcount_n;
      end
   end

endmodule
